// File: rtl/micro_sequencer_if.sv
// ---------------------------------------------------------------------------
// micro_sequencer_if
// Purpose : Bundles the microword controls and the sequencer status signals
//           that pass between the microstore/decoder side and the
//           micro_sequencer.
// Signals :
//   enc_state  dispatch target from the instruction encoder (0 = null IR)
//   ns_sel     next-address control field of the current microword
//   cr_addr    literal jump target from the current microword
//   cond_true  condition-code test result for the current IR/microword
//   moc        memory operation complete (level)
//   state      current microstate, used as the microstore address
//   mem_wait   high while the sequencer is stalled waiting on moc
//   abort      one-cycle pulse after a memory timeout
//   retire     one-cycle pulse after a return to the fetch microstate
//   wait_cnt   consecutive moc wait count (debug)
// Modports:
//   master  drives the microword/encoder/memory inputs, observes status
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface micro_sequencer_if #(
    parameter int STATE_W = 8
);
    logic [STATE_W-1:0] enc_state;
    logic [2:0]         ns_sel;
    logic [STATE_W-1:0] cr_addr;
    logic               cond_true;
    logic               moc;
    logic [STATE_W-1:0] state;
    logic               mem_wait;
    logic               abort;
    logic               retire;
    logic [7:0]         wait_cnt;

    modport master (
        output enc_state, ns_sel, cr_addr, cond_true, moc,
        input  state, mem_wait, abort, retire, wait_cnt
    );

    modport slave (
        input  enc_state, ns_sel, cr_addr, cond_true, moc,
        output state, mem_wait, abort, retire, wait_cnt
    );
endinterface

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
// Purpose : Next-state sequencer for the microprogrammed control unit. Holds
//           the microstate register that addresses the microstore and picks
//           the next microstate from the microword next-address field. Also
//           supervises the memory handshake with a timeout and flags
//           instruction retirement.
// Ports   :
//   clk     system clock, rising edge
//   reset   asynchronous, active-high reset
//   io_seq  micro_sequencer_if.slave bundle (see interface for signals)
// ---------------------------------------------------------------------------
module micro_sequencer #(
    parameter int STATE_W     = 8,
    parameter int FETCH_STATE = 1,
    parameter int ABORT_STATE = 63,
    parameter int MOC_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.slave  io_seq
);

    typedef enum logic [2:0] {
        NS_INC       = 3'b000,
        NS_DISPATCH  = 3'b001,
        NS_JUMP      = 3'b010,
        NS_CJUMP     = 3'b011,
        NS_MEMWAIT   = 3'b100,
        NS_CDISPATCH = 3'b101,
        NS_FETCH     = 3'b110,
        NS_HOLD      = 3'b111
    } nsSel_t;

    localparam logic [STATE_W-1:0] FETCH_ADDR = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] ABORT_ADDR = STATE_W'(ABORT_STATE);
    localparam logic [7:0]         WAIT_LAST  = 8'(MOC_TIMEOUT - 1);

    logic [STATE_W-1:0] r_state;
    logic [7:0]         r_waitCnt;
    logic               r_abort;
    logic               r_retire;

    nsSel_t             w_sel;
    logic [STATE_W-1:0] w_stateInc;
    logic [STATE_W-1:0] w_nextState;
    logic [7:0]         w_nextWaitCnt;
    logic               w_nextAbort;
    logic               w_nextRetire;
    logic               w_memWait;

    assign w_sel      = nsSel_t'(io_seq.ns_sel);
    assign w_stateInc = r_state + 1'b1;

    // Next-address decode. Every ns_sel code is listed so no X can leak into
    // the state register. wait_cnt falls back to zero unless the microword
    // is MEMWAIT or HOLD. Returning to fetch retires only through the
    // CDISPATCH-false and FETCH paths; a JUMP/DISPATCH that happens to land
    // on the fetch address does not count as a retirement. In a timeout
    // cycle moc is checked first, so a late completion still wins.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = '0;
        w_nextAbort   = 1'b0;
        w_nextRetire  = 1'b0;
        w_memWait     = 1'b0;
        case (w_sel)
            NS_INC:      w_nextState = w_stateInc;
            NS_DISPATCH: w_nextState = io_seq.enc_state;
            NS_JUMP:     w_nextState = io_seq.cr_addr;
            NS_CJUMP:    w_nextState = io_seq.cond_true ? io_seq.cr_addr : w_stateInc;
            NS_MEMWAIT: begin
                if (io_seq.moc) begin
                    w_nextState = w_stateInc;
                end else begin
                    w_memWait = 1'b1;
                    if (r_waitCnt < WAIT_LAST) begin
                        w_nextWaitCnt = r_waitCnt + 8'd1;
                    end else begin
                        w_nextState = ABORT_ADDR;
                        w_nextAbort = 1'b1;
                    end
                end
            end
            NS_CDISPATCH: begin
                if (io_seq.cond_true) begin
                    w_nextState = io_seq.enc_state;
                end else begin
                    w_nextState  = FETCH_ADDR;
                    w_nextRetire = 1'b1;
                end
            end
            NS_FETCH: begin
                w_nextState  = FETCH_ADDR;
                w_nextRetire = 1'b1;
            end
            NS_HOLD:     w_nextWaitCnt = r_waitCnt;
            default:     w_nextState = r_state;
        endcase
    end

    // Microstate, wait counter and the two status pulses all advance
    // together so abort/retire line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= '0;
            r_waitCnt <= '0;
            r_abort   <= 1'b0;
            r_retire  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            r_abort   <= w_nextAbort;
            r_retire  <= w_nextRetire;
        end
    end

    assign io_seq.state    = r_state;
    assign io_seq.wait_cnt = r_waitCnt;
    assign io_seq.abort    = r_abort;
    assign io_seq.retire   = r_retire;
    assign io_seq.mem_wait = w_memWait;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
// Purpose : Directed, self-checking bench for micro_sequencer with
//           hand-computed expected microstates and status flags.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

   localparam logic [2:0] INC   = 3'b000;
   localparam logic [2:0] DISP  = 3'b001;
   localparam logic [2:0] JUMP  = 3'b010;
   localparam logic [2:0] CJMP  = 3'b011;
   localparam logic [2:0] MWAIT = 3'b100;
   localparam logic [2:0] CDISP = 3'b101;
   localparam logic [2:0] FETCH = 3'b110;
   localparam logic [2:0] HOLD  = 3'b111;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   micro_sequencer_if #(.STATE_W(8)) seqIf ();

   micro_sequencer #(
      .STATE_W(8),
      .FETCH_STATE(1),
      .ABORT_STATE(63),
      .MOC_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .io_seq(seqIf.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expected value and tallies it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drives one microword's worth of inputs; settles combinational outputs.
   task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] enc,
                                input logic [7:0] cr, input logic cond,
                                input logic mocIn);
      seqIf.ns_sel    = sel;
      seqIf.enc_state = enc;
      seqIf.cr_addr   = cr;
      seqIf.cond_true = cond;
      seqIf.moc       = mocIn;
      #1;
   endtask

   // Lets the current microword take effect; samples 1 unit after the edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // One full cycle of a microword, then checks the resulting state.
   task automatic runWord(input string tag, input logic [2:0] sel,
                          input logic [7:0] enc, input logic [7:0] cr,
                          input logic cond, input logic mocIn,
                          input logic [7:0] expState);
      applyStimulus(sel, enc, cr, cond, mocIn);
      stepClock();
      checkOutput(tag, {24'd0, seqIf.state}, {24'd0, expState});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      applyStimulus(INC, 8'd0, 8'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      checkOutput("rst_state", {24'd0, seqIf.state}, 32'd0);
      checkOutput("rst_wait", {24'd0, seqIf.wait_cnt}, 32'd0);
      checkOutput("rst_abort", {31'd0, seqIf.abort}, 32'd0);
      checkOutput("rst_retire", {31'd0, seqIf.retire}, 32'd0);
      reset = 1'b0;

      // First cycle after reset is a normal FETCH from state 0.
      runWord("fetch_from0", FETCH, 8'd0, 8'd0, 1'b0, 1'b0, 8'd1);
      checkOutput("fetch_retire", {31'd0, seqIf.retire}, 32'd1);

      // Plain sequencing and dispatch.
      runWord("inc_a", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd2);
      checkOutput("inc_a_retire", {31'd0, seqIf.retire}, 32'd0);
      runWord("inc_b", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd3);
      runWord("dispatch10", DISP, 8'd10, 8'd0, 1'b0, 1'b0, 8'd10);
      checkOutput("disp_retire", {31'd0, seqIf.retire}, 32'd0);

      // Conditional jump both ways.
      runWord("jump20", JUMP, 8'd0, 8'd20, 1'b0, 1'b0, 8'd20);
      runWord("cjump_false", CJMP, 8'd0, 8'd40, 1'b0, 1'b0, 8'd21);
      runWord("jump20b", JUMP, 8'd0, 8'd20, 1'b0, 1'b0, 8'd20);
      runWord("cjump_true", CJMP, 8'd0, 8'd40, 1'b1, 1'b0, 8'd40);

      // Conditional dispatch: false skips to fetch and retires.
      runWord("jump5", JUMP, 8'd0, 8'd5, 1'b0, 1'b0, 8'd5);
      runWord("cdisp_false", CDISP, 8'd14, 8'd0, 1'b0, 1'b0, 8'd1);
      checkOutput("cdisp_retire", {31'd0, seqIf.retire}, 32'd1);
      runWord("inc_after", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd2);
      checkOutput("retire_one_cycle", {31'd0, seqIf.retire}, 32'd0);
      runWord("cdisp_true", CDISP, 8'd14, 8'd0, 1'b1, 1'b0, 8'd14);
      checkOutput("cdisp_t_retire", {31'd0, seqIf.retire}, 32'd0);

      // Jump or dispatch onto the fetch address must not retire.
      runWord("jump_fetch", JUMP, 8'd0, 8'd1, 1'b0, 1'b0, 8'd1);
      checkOutput("jump_fetch_ret", {31'd0, seqIf.retire}, 32'd0);
      runWord("disp_fetch", DISP, 8'd1, 8'd0, 1'b0, 1'b0, 8'd1);
      checkOutput("disp_fetch_ret", {31'd0, seqIf.retire}, 32'd0);

      // Memory wait: three stalled cycles then completion.
      runWord("jump17", JUMP, 8'd0, 8'd17, 1'b0, 1'b0, 8'd17);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(MWAIT, 8'd0, 8'd0, 1'b0, 1'b0);
         checkOutput("memwait_flag", {31'd0, seqIf.mem_wait}, 32'd1);
         stepClock();
         checkOutput("memwait_hold", {24'd0, seqIf.state}, 32'd17);
         checkOutput("memwait_cnt", {24'd0, seqIf.wait_cnt}, k);
      end
      applyStimulus(MWAIT, 8'd0, 8'd0, 1'b0, 1'b1);
      checkOutput("moc_nowait", {31'd0, seqIf.mem_wait}, 32'd0);
      stepClock();
      checkOutput("moc_state", {24'd0, seqIf.state}, 32'd18);
      checkOutput("moc_cnt", {24'd0, seqIf.wait_cnt}, 32'd0);

      // Timeout: 16 cycles with moc low lands in the abort microstate.
      runWord("jump30", JUMP, 8'd0, 8'd30, 1'b0, 1'b0, 8'd30);
      for (int k = 1; k <= 15; k++) begin
         runWord("to_hold", MWAIT, 8'd0, 8'd0, 1'b0, 1'b0, 8'd30);
         checkOutput("to_noabort", {31'd0, seqIf.abort}, 32'd0);
      end
      checkOutput("to_cnt15", {24'd0, seqIf.wait_cnt}, 32'd15);
      applyStimulus(MWAIT, 8'd0, 8'd0, 1'b0, 1'b0);
      checkOutput("to_memwait", {31'd0, seqIf.mem_wait}, 32'd1);
      stepClock();
      checkOutput("to_state", {24'd0, seqIf.state}, 32'd63);
      checkOutput("to_abort", {31'd0, seqIf.abort}, 32'd1);
      checkOutput("to_retire", {31'd0, seqIf.retire}, 32'd0);
      checkOutput("to_cnt0", {24'd0, seqIf.wait_cnt}, 32'd0);
      runWord("after_abort", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd64);
      checkOutput("abort_one_cycle", {31'd0, seqIf.abort}, 32'd0);

      // Timeout repeated with moc rising in the 16th cycle: moc wins.
      runWord("jump30b", JUMP, 8'd0, 8'd30, 1'b0, 1'b0, 8'd30);
      for (int k = 1; k <= 15; k++) begin
         runWord("late_hold", MWAIT, 8'd0, 8'd0, 1'b0, 1'b0, 8'd30);
      end
      runWord("late_moc", MWAIT, 8'd0, 8'd0, 1'b0, 1'b1, 8'd31);
      checkOutput("late_noabort", {31'd0, seqIf.abort}, 32'd0);
      checkOutput("late_cnt", {24'd0, seqIf.wait_cnt}, 32'd0);

      // HOLD keeps both the state and the wait count; INC clears the count.
      runWord("jump50", JUMP, 8'd0, 8'd50, 1'b0, 1'b0, 8'd50);
      runWord("mw50a", MWAIT, 8'd0, 8'd0, 1'b0, 1'b0, 8'd50);
      runWord("mw50b", MWAIT, 8'd0, 8'd0, 1'b0, 1'b0, 8'd50);
      runWord("hold50", HOLD, 8'd0, 8'd0, 1'b0, 1'b0, 8'd50);
      checkOutput("hold_cnt", {24'd0, seqIf.wait_cnt}, 32'd2);
      runWord("inc51", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd51);
      checkOutput("inc_clr_cnt", {24'd0, seqIf.wait_cnt}, 32'd0);

      // Wrap, fetch from far away, null-IR dispatch.
      runWord("jump255", JUMP, 8'd0, 8'd255, 1'b0, 1'b0, 8'd255);
      runWord("wrap", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
      runWord("jump200", JUMP, 8'd0, 8'd200, 1'b0, 1'b0, 8'd200);
      runWord("fetch200", FETCH, 8'd0, 8'd0, 1'b0, 1'b0, 8'd1);
      checkOutput("fetch200_ret", {31'd0, seqIf.retire}, 32'd1);
      runWord("null_ir", DISP, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);

      // Asynchronous reset in the middle of a wait with wait_cnt=5.
      runWord("jump17b", JUMP, 8'd0, 8'd17, 1'b0, 1'b0, 8'd17);
      for (int k = 1; k <= 5; k++) begin
         runWord("pre_rst", MWAIT, 8'd0, 8'd0, 1'b0, 1'b0, 8'd17);
      end
      checkOutput("pre_rst_cnt", {24'd0, seqIf.wait_cnt}, 32'd5);
      reset = 1'b1;
      #1;
      checkOutput("arst_state", {24'd0, seqIf.state}, 32'd0);
      checkOutput("arst_cnt", {24'd0, seqIf.wait_cnt}, 32'd0);
      checkOutput("arst_abort", {31'd0, seqIf.abort}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      runWord("post_rst_inc", INC, 8'd0, 8'd0, 1'b0, 1'b0, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
